dial_level_pwm: RTL and testbench
=================================

// Module: dial_level_pwm
// PURPOSE
// - Consumer of the rotary encoder stage: turns its free-running 8-bit step counter and error toggle into a
//   saturating brightness level.
// - Drives a PWM LED from that level; the debounced pushbutton gives mute (short press) and clear (long press).
// - Sits between the encoder/debounce outputs and the top-level LED pins.
// PARAMETERS
// - CNT_W          8     width of encoder count input
// - LEVEL_W        5     level width; level range 0..2^LEVEL_W-1
// - STEPS_PER_DET  4     encoder counts per level step (one detent)
// - PWM_W          8     PWM counter width; period = 2^PWM_W clk; PWM_W >= LEVEL_W
// - LONG_CYCLES    8000000  press length (clk) that counts as a long press (0.5 s at 16 MHz)
// PORTS
// - clk        in   1        system clock (16 MHz)
// - rst_n      in   1        asynchronous active-low reset
// - count      in   CNT_W    encoder step counter, wraps modulo 2^CNT_W
// - enc_err    in   1        encoder error signal; toggles once per illegal transition
// - btn_n      in   1        debounced pushbutton, 0 = pressed
// - level      out  LEVEL_W  current brightness level
// - step_up    out  1        1-cycle pulse on each level increment
// - step_dn    out  1        1-cycle pulse on each level decrement
// - muted      out  1        mute state
// - err_flag   out  1        sticky encoder-fault flag
// - pwm_out    out  1        PWM LED drive, active high
// BEHAVIOUR
// - Reset (async, rst_n=0): level=0, acc=0, muted=0, err_flag=0, step_up=step_dn=0, pwm_out=0, pwm_cnt=0,
//   primed=0, button FSM=IDLE. Reset mid-press: the press is abandoned, and the FSM needs btn_n=1 before the next press.
// - Priming: first clk edge after reset loads prev_count<=count and prev_err<=enc_err with no delta applied; primed<=1.
// - Delta, each edge once primed: delta = (count - prev_count) mod 2^CNT_W, read as signed.
//   - 0xFF->0x00 = +1; 0x00->0xFF = -1.
//   - prev_count<=count every edge.
// - |delta|>1: err_flag<=1; delta discarded; acc and level unchanged.
// - Accumulator acc, signed, range -(STEPS_PER_DET-1)..+(STEPS_PER_DET-1): acc+delta==+STEPS_PER_DET ->
//   - level<MAX: level+1, step_up=1.
//   - level==MAX: level holds, no pulse.
//   - acc<=0 in both cases.
//   Mirror rule at -STEPS_PER_DET: decrement, step_dn, saturate at 0.
// - Latency: level/step pulse update on the same edge that first samples the completing count value.
// - enc_err: any change vs prev_err sets err_flag=1 on that edge. err_flag is sticky; only a long press or reset
//   clears it.
// - Button FSM (press = btn_n 1->0, sampled per edge):
//   - IDLE: press -> PRESS, hold_cnt<=0.
//   - PRESS: hold_cnt++ while btn_n=0.
//     - Release before hold_cnt reaches LONG_CYCLES-1 -> muted<=~muted, go to IDLE.
//     - hold_cnt reaches LONG_CYCLES-1 -> level<=0, acc<=0, err_flag<=0, go to HELD. muted is unchanged.
//   - HELD: wait for btn_n=1 -> IDLE. No further action.
// - Simultaneous events: long-press clear beats a detent step and an error set in the same cycle.
//   The clear cycle emits no step pulse.
// - PWM:
//   - pwm_cnt free-runs 0..2^PWM_W-1 and wraps.
//   - duty_sh<=level only when pwm_cnt==all-ones, so updates take effect at a period boundary with no glitch.
//   - pwm_out registered = !muted && (pwm_cnt[PWM_W-1 -: LEVEL_W] < duty_sh).
//   - level 0 gives constant 0. MAX gives (2^LEVEL_W-1)/2^LEVEL_W duty.
//   - Mute forces pwm_out=0 on the next edge.
// - Level keeps tracking the encoder while muted.
// TESTING
// - Reset with count=0x37, enc_err=1, both held 20 clk -> level=0, err_flag=0, no step pulses (priming works).
// - From count=0xFE, step +1 every 2 clk for 8 steps (wrap to 0x06) -> level=2, exactly 2 step_up pulses,
//   each on the 4th and 8th step edge.
// - Level=31, apply +4 counts -> level=31, no step_up, acc=0.
//   Then -4 counts -> level=30, one step_dn.
// - count jumps 0x10->0x13 in one edge -> err_flag=1, level unchanged. A toggle of enc_err alone also sets err_flag.
// - LONG_CYCLES=1000, level=16: press 100 clk -> muted=1, pwm_out stays 0 for a full period.
//   Press again -> muted=0, pwm_out high 128 of 256 clk per period.
// - LONG_CYCLES=1000, level=9, err_flag=1: hold 1500 clk -> at cycle 1000 level=0, err_flag=0, muted unchanged;
//   release -> IDLE, no mute toggle.

Source files
------------

// File: rtl/dial_level_pwm.sv
// Rotary-encoder level tracker with saturating brightness level, button mute/clear and PWM LED drive.
// Consumes a free-running encoder step counter and a toggling error line.
module dial_level_pwm #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned LEVEL_W       = 5,
  parameter int unsigned STEPS_PER_DET = 4,
  parameter int unsigned PWM_W         = 8,
  parameter int unsigned LONG_CYCLES   = 8000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   count,
  input  logic               enc_err,
  input  logic               btn_n,
  output logic [LEVEL_W-1:0] level,
  output logic               step_up,
  output logic               step_dn,
  output logic               muted,
  output logic               err_flag,
  output logic               pwm_out
);

  localparam int unsigned ACC_W  = $clog2(STEPS_PER_DET) + 2;
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic signed [ACC_W-1:0]  STEP_P    = ACC_W'(STEPS_PER_DET);
  localparam logic signed [ACC_W-1:0]  STEP_N    = -STEP_P;
  localparam logic signed [CNT_W-1:0]  D_ONE     = CNT_W'(1);
  localparam logic signed [CNT_W-1:0]  D_MONE    = -D_ONE;
  localparam logic [LEVEL_W-1:0]       LEVEL_MAX = {LEVEL_W{1'b1}};
  localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPress, StHeld} btn_state_e;

  btn_state_e                state_q, state_d;
  logic [HOLD_W-1:0]         hold_cnt_q, hold_cnt_d;
  logic                      btn_prev_q;
  logic                      primed_q;
  logic [CNT_W-1:0]          prev_count_q;
  logic                      prev_err_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [LEVEL_W-1:0]        level_q, level_d;
  logic                      step_up_q, step_up_d, step_dn_q, step_dn_d;
  logic                      muted_q, muted_d;
  logic                      err_q, err_d;
  logic [PWM_W-1:0]          pwm_cnt_q;
  logic [LEVEL_W-1:0]        duty_sh_q, duty_sh_d;
  logic                      pwm_out_q, pwm_out_d;

  logic                      mute_toggle, long_clear, jump;
  logic signed [CNT_W-1:0]   delta;
  logic signed [ACC_W-1:0]   step_sum;

  // Button FSM; btn_prev resets to "pressed" so a held button must be released before it counts.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    mute_toggle = 1'b0;
    long_clear  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_prev_q && !btn_n) begin
          state_d    = StPress;
          hold_cnt_d = '0;
        end
      end
      StPress: begin
        if (btn_n) begin
          mute_toggle = 1'b1;
          state_d     = StIdle;
        end else if (hold_cnt_q == HOLD_LAST) begin
          long_clear = 1'b1;
          state_d    = StHeld;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (btn_n) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    delta     = count - prev_count_q;
    jump      = (delta > D_ONE) || (delta < D_MONE);
    step_sum  = acc_q + ACC_W'(delta);
    acc_d     = acc_q;
    level_d   = level_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    err_d     = err_q;
    if (primed_q && !jump) begin
      if (step_sum == STEP_P) begin
        acc_d = '0;
        if (level_q != LEVEL_MAX) begin
          level_d   = level_q + 1'b1;
          step_up_d = 1'b1;
        end
      end else if (step_sum == STEP_N) begin
        acc_d = '0;
        if (level_q != '0) begin
          level_d   = level_q - 1'b1;
          step_dn_d = 1'b1;
        end
      end else begin
        acc_d = step_sum;
      end
    end
    if (primed_q && (jump || (enc_err != prev_err_q))) err_d = 1'b1;
    // Long-press clear overrides any step or error set on the same edge.
    if (long_clear) begin
      level_d   = '0;
      acc_d     = '0;
      err_d     = 1'b0;
      step_up_d = 1'b0;
      step_dn_d = 1'b0;
    end
    muted_d = muted_q ^ mute_toggle;
  end

  // Duty is latched only at the end of a period so level changes never cut a pulse short.
  always_comb begin
    duty_sh_d = (pwm_cnt_q == '1) ? level_q : duty_sh_q;
    pwm_out_d = !muted_q && (pwm_cnt_q[PWM_W-1 -: LEVEL_W] < duty_sh_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hold_cnt_q   <= '0;
      btn_prev_q   <= 1'b0;
      primed_q     <= 1'b0;
      prev_count_q <= '0;
      prev_err_q   <= 1'b0;
      acc_q        <= '0;
      level_q      <= '0;
      step_up_q    <= 1'b0;
      step_dn_q    <= 1'b0;
      muted_q      <= 1'b0;
      err_q        <= 1'b0;
      pwm_cnt_q    <= '0;
      duty_sh_q    <= '0;
      pwm_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      btn_prev_q   <= btn_n;
      primed_q     <= 1'b1;
      prev_count_q <= count;
      prev_err_q   <= enc_err;
      acc_q        <= acc_d;
      level_q      <= level_d;
      step_up_q    <= step_up_d;
      step_dn_q    <= step_dn_d;
      muted_q      <= muted_d;
      err_q        <= err_d;
      pwm_cnt_q    <= pwm_cnt_q + 1'b1;
      duty_sh_q    <= duty_sh_d;
      pwm_out_q    <= pwm_out_d;
    end
  end

  assign level    = level_q;
  assign step_up  = step_up_q;
  assign step_dn  = step_dn_q;
  assign muted    = muted_q;
  assign err_flag = err_q;
  assign pwm_out  = pwm_out_q;

endmodule

// File: tb/tb_dial_level_pwm.sv
// Bench for dial_level_pwm: directed scenarios plus random stimulus, all outputs
// compared every cycle against an integer-arithmetic reference model.
module tb_dial_level_pwm;

  localparam int LONG = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] count = 8'h00;
  logic       enc_err = 1'b0;
  logic       btn_n = 1'b1;
  logic [4:0] level;
  logic       step_up, step_dn, muted, err_flag, pwm_out;

  int errors = 0;
  int checks = 0;

  dial_level_pwm #(
    .CNT_W(8), .LEVEL_W(5), .STEPS_PER_DET(4), .PWM_W(8), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .count(count), .enc_err(enc_err), .btn_n(btn_n),
    .level(level), .step_up(step_up), .step_dn(step_dn), .muted(muted),
    .err_flag(err_flag), .pwm_out(pwm_out)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer state, advanced once per clock edge from the rules.
  int m_primed, m_prev_cnt, m_prev_err, m_acc, m_level, m_up, m_dn, m_muted, m_err;
  int m_pwm, m_phase, m_duty, m_bst, m_hold, m_btn_prev;

  task automatic model_reset();
    m_primed = 0; m_prev_cnt = 0; m_prev_err = 0; m_acc = 0; m_level = 0;
    m_up = 0; m_dn = 0; m_muted = 0; m_err = 0; m_pwm = 0; m_phase = 0;
    m_duty = 0; m_bst = 0; m_hold = 0; m_btn_prev = 0;
  endtask

  task automatic model_edge();
    int  d, s, new_pwm;
    bit  jump, toggle, clr;
    new_pwm = (m_muted == 0 && (m_phase / 8) < m_duty) ? 1 : 0;
    if (m_phase == 255) m_duty = m_level;
    m_phase = (m_phase + 1) % 256;
    toggle = 0;
    clr = 0;
    case (m_bst)
      0: if (m_btn_prev == 1 && btn_n == 1'b0) begin m_bst = 1; m_hold = 0; end
      1: begin
        if (btn_n) begin toggle = 1; m_bst = 0; end
        else if (m_hold == LONG - 1) begin clr = 1; m_bst = 2; end
        else m_hold++;
      end
      default: if (btn_n) m_bst = 0;
    endcase
    m_btn_prev = int'(btn_n);
    m_up = 0;
    m_dn = 0;
    if (m_primed == 1) begin
      d = (int'(count) - m_prev_cnt + 256) % 256;
      if (d >= 128) d -= 256;
      jump = (d > 1) || (d < -1);
      if (!jump) begin
        s = m_acc + d;
        if (s == 4) begin
          m_acc = 0;
          if (m_level < 31) begin m_level++; m_up = 1; end
        end else if (s == -4) begin
          m_acc = 0;
          if (m_level > 0) begin m_level--; m_dn = 1; end
        end else m_acc = s;
      end
      if (jump || int'(enc_err) != m_prev_err) m_err = 1;
    end
    m_primed = 1;
    m_prev_cnt = int'(count);
    m_prev_err = int'(enc_err);
    if (clr) begin m_level = 0; m_acc = 0; m_err = 0; m_up = 0; m_dn = 0; end
    if (toggle) m_muted = 1 - m_muted;
    m_pwm = new_pwm;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("level", 32'(level), m_level);
    chk("step_up", 32'(step_up), m_up);
    chk("step_dn", 32'(step_dn), m_dn);
    chk("muted", 32'(muted), m_muted);
    chk("err_flag", 32'(err_flag), m_err);
    chk("pwm_out", 32'(pwm_out), m_pwm);
  end

  int ups, dns, step_no, hi, btn_left;
  int up_at[$];

  // Called at a negedge; returns at a negedge.
  task automatic do_reset(input int n);
    #1 rst_n = 1'b0;
    repeat (n) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic step(input int d);
    count = count + 8'(d);
    step_no++;
    repeat (2) begin
      @(negedge clk);
      if (step_up) begin ups++; up_at.push_back(step_no); end
      if (step_dn) dns++;
    end
  endtask

  task automatic count_high();
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
  endtask

  initial begin
    // Priming: count and enc_err held at non-zero values through reset.
    count = 8'h37;
    enc_err = 1'b1;
    @(negedge clk);
    do_reset(20);
    repeat (5) @(negedge clk);
    chk("prime_level", 32'(level), 0);
    chk("prime_err", 32'(err_flag), 0);

    // Wrapping ramp from 0xFE.
    count = 8'hFE;
    enc_err = 1'b0;
    do_reset(3);
    repeat (2) @(negedge clk);
    ups = 0; step_no = 0; up_at.delete();
    for (int i = 0; i < 8; i++) step(1);
    chk("ramp_count", 32'(count), 6);
    chk("ramp_level", 32'(level), 2);
    chk("ramp_ups", 32'(ups), 2);
    chk("ramp_up_at0", 32'((up_at.size() > 0) ? up_at[0] : -1), 4);
    chk("ramp_up_at1", 32'((up_at.size() > 1) ? up_at[1] : -1), 8);

    // Saturate at the top, then step down once.
    for (int i = 0; i < 116; i++) step(1);
    chk("top_level", 32'(level), 31);
    ups = 0;
    for (int i = 0; i < 4; i++) step(1);
    chk("sat_level", 32'(level), 31);
    chk("sat_ups", 32'(ups), 0);
    chk("model_acc", 32'(m_acc), 0);
    dns = 0;
    for (int i = 0; i < 4; i++) step(-1);
    chk("dn_level", 32'(level), 30);
    chk("dn_pulses", 32'(dns), 1);

    // Jump of +3 in one edge.
    count = count + 8'd3;
    repeat (2) @(negedge clk);
    chk("jump_err", 32'(err_flag), 1);
    chk("jump_level", 32'(level), 30);

    // Down to 9, then long press clears level and error without touching mute.
    for (int i = 0; i < 84; i++) step(-1);
    chk("pre_long_level", 32'(level), 9);
    btn_n = 1'b0;
    repeat (1000) @(negedge clk);
    chk("long_before", 32'(level), 9);
    @(negedge clk);
    chk("long_level", 32'(level), 0);
    chk("long_err", 32'(err_flag), 0);
    chk("long_muted", 32'(muted), 0);
    repeat (499) @(negedge clk);
    btn_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("long_rel_muted", 32'(muted), 0);

    // enc_err toggle alone.
    enc_err = ~enc_err;
    repeat (2) @(negedge clk);
    chk("toggle_err", 32'(err_flag), 1);

    // Level 16 mute / unmute with PWM duty.
    for (int i = 0; i < 64; i++) step(1);
    chk("mid_level", 32'(level), 16);
    btn_n = 1'b0;
    repeat (100) @(negedge clk);
    btn_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mute_on", 32'(muted), 1);
    count_high();
    chk("mute_pwm_high", 32'(hi), 0);
    btn_n = 1'b0;
    repeat (100) @(negedge clk);
    btn_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mute_off", 32'(muted), 0);
    repeat (300) @(negedge clk);
    count_high();
    chk("pwm_high_16", 32'(hi), 128);

    // Random phase, including one reset in the middle of a press.
    btn_left = 0;
    for (int i = 0; i < 5000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 30) count = count + 8'd1;
      else if (r < 60) count = count - 8'd1;
      else if (r == 60) count = count + 8'($urandom_range(2, 254));
      if ($urandom_range(0, 299) == 0) enc_err = ~enc_err;
      if (btn_left > 0) begin
        btn_left--;
        if (btn_left == 0) btn_n = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        btn_n = 1'b0;
        btn_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(995, 1010))
                                               : int'($urandom_range(1, 60));
      end
      if (i == 2500) begin
        btn_n = 1'b0;
        btn_left = 40;
        do_reset(3);
      end else begin
        @(negedge clk);
      end
    end
    btn_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
